// File: rtl/parking_pkg.sv
// Shared constants and FSM state type for the parking slot tracker.
package parking_pkg;

  localparam int SLOTS  = 8;
  localparam int SLOT_W = 3;
  localparam int GATE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GATE  = 2'd2
  } state_t;

endpackage : parking_pkg

// File: rtl/lowest_free_slot.sv
// Combinational priority encoder: index of the lowest clear bit in the occupancy vector.
module lowest_free_slot
  import parking_pkg::*;
(
  input  logic [SLOTS-1:0]  occupancy,
  output logic [SLOT_W-1:0] free_idx,
  output logic              none_free
);

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    free_idx  = '0;
    none_free = 1'b1;
    // Scan downwards so the lowest free slot is the last one written and wins.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        free_idx  = SLOT_W'(i);
        none_free = 1'b0;
      end
    end
  end

endmodule : lowest_free_slot

// File: rtl/parking_slot_tracker.sv
// Slot allocator: grants the lowest free slot, times the entry gate, retires slots on exit.
// Define PARKING_STATS_EN to build the entries_total counter; otherwise it reads as 0.
module parking_slot_tracker
  import parking_pkg::*;
#(
  parameter int GATE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enter_req,
  input  logic              exit_req,
  input  logic [SLOT_W-1:0] exit_slot,
  output logic [SLOTS-1:0]  occupancy,
  output logic              full,
  output logic              enter_grant,
  output logic [SLOT_W-1:0] grant_slot,
  output logic              enter_reject,
  output logic              gate_open,
  output logic              exit_err,
  output logic [7:0]        entries_total
);

  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

  state_t              state;
  logic [GATE_W-1:0]   gate_cnt;
  logic [SLOT_W-1:0]   free_idx;
  logic                none_free;
  logic                take_grant;
  logic                take_reject;
  logic                exit_miss;
  logic [SLOTS-1:0]    set_mask;
  logic [SLOTS-1:0]    clr_mask;
  logic [SLOTS-1:0]    occ_next;

  lowest_free_slot u_lowest_free (
    .occupancy (occupancy),
    .free_idx  (free_idx),
    .none_free (none_free)
  );

  // Requests are ignored while a reject pulse is still high, so a held
  // request against a full lot re-rejects every second cycle.
  always_comb begin
    take_grant  = (state == IDLE) && enter_req && !enter_reject && !none_free;
    take_reject = (state == IDLE) && enter_req && !enter_reject &&  none_free;
    exit_miss   = exit_req && !occupancy[exit_slot];
    set_mask    = '0;
    clr_mask    = '0;
    if (take_grant) set_mask[free_idx] = 1'b1;
    if (exit_req && occupancy[exit_slot]) clr_mask[exit_slot] = 1'b1;
    occ_next    = (occupancy | set_mask) & ~clr_mask;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      gate_cnt     <= '0;
      occupancy    <= '0;
      full         <= 1'b0;
      enter_grant  <= 1'b0;
      grant_slot   <= '0;
      enter_reject <= 1'b0;
      gate_open    <= 1'b0;
      exit_err     <= 1'b0;
    end else begin
      occupancy    <= occ_next;
      full         <= &occ_next;
      exit_err     <= exit_miss;
      enter_grant  <= 1'b0;
      enter_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (take_grant) begin
            state       <= GRANT;
            grant_slot  <= free_idx;
            enter_grant <= 1'b1;
          end else if (take_reject) begin
            enter_reject <= 1'b1;
          end
        end
        GRANT: begin
          state     <= GATE;
          gate_cnt  <= GATE_LOAD;
          gate_open <= 1'b1;
        end
        GATE: begin
          if (gate_cnt == '0) begin
            state     <= IDLE;
            gate_open <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          gate_open <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARKING_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             entries_total <= '0;
    else if (take_grant) entries_total <= entries_total + 8'd1;
  end
`else
  assign entries_total = '0;
`endif

endmodule : parking_slot_tracker

// File: tb/tb_parking_slot_tracker.sv
// Scoreboard bench for parking_slot_tracker: stimulus pushes expected events, a monitor pops them.
`timescale 1ns/1ps
module tb_parking_slot_tracker;

  localparam int GC = 4;

  typedef enum logic [1:0] {EV_GRANT = 2'd0, EV_REJECT = 2'd1, EV_ERR = 2'd2} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [2:0] slot;
    logic [7:0] occ;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [2:0] exit_slot = '0;
  logic [7:0] occupancy;
  logic       full;
  logic       enter_grant;
  logic [2:0] grant_slot;
  logic       enter_reject;
  logic       gate_open;
  logic       exit_err;
  logic [7:0] entries_total;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  gate_len = 0;

  parking_slot_tracker #(.GATE_CYCLES(GC)) dut (
    .clk           (clk),
    .rst           (rst),
    .enter_req     (enter_req),
    .exit_req      (exit_req),
    .exit_slot     (exit_slot),
    .occupancy     (occupancy),
    .full          (full),
    .enter_grant   (enter_grant),
    .grant_slot    (grant_slot),
    .enter_reject  (enter_reject),
    .gate_open     (gate_open),
    .exit_err      (exit_err),
    .entries_total (entries_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input ev_kind_t k, input logic [2:0] s, input logic [7:0] o);
    ev_t e;
    e.kind = k; e.slot = s; e.occ = o;
    sb.push_back(e);
  endtask

  // Monitor: compare every output event against the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      gate_len = 0;
    end else begin
      if (enter_grant) begin
        if (sb.size() == 0) check("unexpected_grant", 1, 0);
        else begin
          e = sb.pop_front();
          check("grant_kind", 32'(e.kind), 32'(EV_GRANT));
          check("grant_slot", 32'(grant_slot), 32'(e.slot));
          check("grant_occ", 32'(occupancy), 32'(e.occ));
        end
      end
      if (enter_reject) begin
        if (sb.size() == 0) check("unexpected_reject", 1, 0);
        else begin
          e = sb.pop_front();
          check("reject_kind", 32'(e.kind), 32'(EV_REJECT));
          check("reject_occ", 32'(occupancy), 32'(e.occ));
        end
      end
      if (exit_err) begin
        if (sb.size() == 0) check("unexpected_exit_err", 1, 0);
        else begin
          e = sb.pop_front();
          check("err_kind", 32'(e.kind), 32'(EV_ERR));
          check("err_occ", 32'(occupancy), 32'(e.occ));
        end
      end
      if (gate_open) gate_len++;
      else if (gate_len != 0) begin
        check("gate_burst_len", gate_len, GC);
        gate_len = 0;
      end
    end
  end

  task automatic wait_grant();
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exit_req = 1'b0;
      if (enter_grant) begin got = 1; break; end
    end
    enter_req = 1'b0;
    if (!got) check("grant_timeout", 0, 1);
  endtask

  task automatic do_entry(input logic [2:0] s, input logic [7:0] o,
                          input bit with_exit, input logic [2:0] ex_slot);
    bit seen = 0;
    push(EV_GRANT, s, o);
    @(negedge clk);
    enter_req = 1'b1;
    exit_req  = with_exit;
    exit_slot = ex_slot;
    wait_grant();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gate_open) seen = 1;
      else if (seen) break;
    end
    if (!seen || gate_open) check("gate_timeout", 0, 1);
  endtask

  task automatic do_exit(input logic [2:0] s, input bit exp_err, input logic [7:0] o);
    if (exp_err) push(EV_ERR, 3'd0, o);
    @(negedge clk);
    exit_req  = 1'b1;
    exit_slot = s;
    @(negedge clk);
    exit_req  = 1'b0;
    check("exit_occ", 32'(occupancy), 32'(o));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_full", 32'(full), 0);
    check("rst_gate", 32'(gate_open), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_occ", 32'(occupancy), 0);
    check("idle_grant", 32'(enter_grant), 0);
    check("idle_grant_slot", 32'(grant_slot), 0);
    check("idle_reject", 32'(enter_reject), 0);
    check("idle_exit_err", 32'(exit_err), 0);
    check("idle_entries", 32'(entries_total), 0);

    // Fill the lot: slots assigned in ascending order.
    for (int i = 0; i < 8; i++)
      do_entry(3'(i), 8'((16'h1 << (i + 1)) - 1), 0, 3'd0);
    check("fill_occ", 32'(occupancy), 32'h0000_00FF);
    check("fill_full", 32'(full), 1);
    check("grant_slot_hold", 32'(grant_slot), 7);
`ifdef PARKING_STATS_EN
    check("entries_after_fill", 32'(entries_total), 8);
`else
    check("entries_tied_zero", 32'(entries_total), 0);
`endif

    // Reject while full.
    push(EV_REJECT, 3'd0, 8'hFF);
    @(negedge clk);
    enter_req = 1'b1;
    begin
      bit got = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (enter_reject) begin got = 1; break; end
      end
      if (!got) check("reject_timeout", 0, 1);
    end
    enter_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reject_occ_hold", 32'(occupancy), 32'h0000_00FF);

    // Exit slot 3, then re-entry takes slot 3.
    do_exit(3'd3, 0, 8'hF7);
    check("exit_full_clear", 32'(full), 0);
    do_entry(3'd3, 8'hFF, 0, 3'd0);

    // Down to 8'h0F, then exit a free slot.
    do_exit(3'd7, 0, 8'h7F);
    do_exit(3'd6, 0, 8'h3F);
    do_exit(3'd5, 0, 8'h1F);
    do_exit(3'd4, 0, 8'h0F);
    do_exit(3'd5, 1, 8'h0F);

    // Simultaneous exit of slot 0 and grant of slot 2 from 8'h03.
    do_exit(3'd3, 0, 8'h07);
    do_exit(3'd2, 0, 8'h03);
    do_entry(3'd2, 8'h06, 1, 3'd0);

    // Reset mid-GATE: gate drops without waiting for a clock edge.
    push(EV_GRANT, 3'd0, 8'h07);
    @(negedge clk);
    enter_req = 1'b1;
    wait_grant();
    repeat (2) @(negedge clk);
    check("gate_before_rst", 32'(gate_open), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_gate", 32'(gate_open), 0);
    check("rst_async_occ", 32'(occupancy), 0);
    check("rst_async_full", 32'(full), 0);
    check("rst_async_entries", 32'(entries_total), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

`ifdef PARKING_STATS_EN
    // 256 grants wrap the entry counter back to 0.
    for (int n = 0; n < 256; n++) begin
      do_entry(3'd0, 8'h01, 0, 3'd0);
      if (n == 0) check("entries_first", 32'(entries_total), 1);
      do_exit(3'd0, 0, 8'h00);
    end
    check("entries_wrap", 32'(entries_total), 0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_parking_slot_tracker
